// File: rtl/elevador_pkg.sv
// elevador_pkg
// Shared types and default constants for the elevator car door controller.
//   door_state_e        door FSM state encoding
//   DEF_MOTION_TIMEOUT  max cycles for a full door stroke (3 s at 100 MHz)
//   DEF_GUARD           cycles timeExpired is ignored after a restart pulse
//   DEF_MAX_REOPEN      reopens tolerated before nudging (NUDGE_EN builds)
package elevador_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED    = 3'd0,
    ST_OPENING   = 3'd1,
    ST_OPEN_WAIT = 3'd2,
    ST_CLOSING   = 3'd3,
    ST_FAULT     = 3'd4,
    ST_NUDGE     = 3'd5
  } door_state_e;

  localparam logic [31:0] DEF_MOTION_TIMEOUT = 32'd300_000_000;
  localparam int unsigned DEF_GUARD          = 2;
  localparam int unsigned DEF_MAX_REOPEN     = 3;

endpackage

// File: rtl/puerta_watchdog.sv
// puerta_watchdog
// Saturating 32-bit motion counter guarding a door stroke.
//   clk     system clock
//   rst     asynchronous active-high reset
//   clr     restart the count (state entry)
//   en      count this cycle (door motor is driving)
//   expire  the count reaches TIMEOUT on the coming edge
module puerta_watchdog
  import elevador_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = DEF_MOTION_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // Compare one below the limit so the state leaves on the very edge
  // where the count would reach TIMEOUT, i.e. after TIMEOUT cycles.
  localparam logic [31:0] LAST = TIMEOUT - 32'd1;

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q >= LAST);

endmodule

// File: rtl/controlador_puerta.sv
// controlador_puerta
// Elevator car door controller. Initiator of the door-timer handshake,
// sequences the door motor from the limit switches and holds the car while
// the door is not safely closed.
// Optional feature macro: NUDGE_EN (adds nudge_buzzer and the NUDGE state).
//   C_100Mhz     system clock
//   reset        asynchronous active-high reset
//   arrived      car levelled at a floor (pulse)
//   open_btn     door-open button
//   close_btn    door-close button
//   obstruction  light curtain blocked
//   lim_open     door fully open
//   lim_closed   door fully closed
//   timeExpired  door timer expired (level)
//   startTimer   timer enable while waiting with the door open
//   restart      one-cycle timer clear
//   motor_open   drive door open
//   motor_close  drive door closed
//   door_busy    car must not move
//   fault        sticky motion timeout
//   nudge_buzzer nudge warning (NUDGE_EN only)
//
// state      | meaning
// CLOSED     | door shut, car free to move
// OPENING    | motor opening, waiting for lim_open
// OPEN_WAIT  | door open, door timer running
// CLOSING    | motor closing, waiting for lim_closed
// NUDGE      | forced slow close with buzzer, curtain ignored
// FAULT      | stroke timed out, only reset leaves
module controlador_puerta
  import elevador_pkg::*;
#(
  parameter logic [31:0] MOTION_TIMEOUT = DEF_MOTION_TIMEOUT,
  parameter int unsigned GUARD          = DEF_GUARD
`ifdef NUDGE_EN
  , parameter int unsigned MAX_REOPEN   = DEF_MAX_REOPEN
`endif
) (
  input  logic C_100Mhz,
  input  logic reset,
  input  logic arrived,
  input  logic open_btn,
  input  logic close_btn,
  input  logic obstruction,
  input  logic lim_open,
  input  logic lim_closed,
  input  logic timeExpired,
  output logic startTimer,
  output logic restart,
  output logic motor_open,
  output logic motor_close,
  output logic door_busy,
  output logic fault
`ifdef NUDGE_EN
  , output logic nudge_buzzer
`endif
);

  localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);

  door_state_e   state_q, state_d;
  logic          restart_q, restart_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          mot_expire;
  logic          mot_en;
  logic          mot_clr;

`ifdef NUDGE_EN
  localparam int RW = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;
  localparam logic [RW-1:0] REOPEN_MAX = RW'(MAX_REOPEN);

  logic [RW-1:0] reopen_q, reopen_d;
`endif

  always_comb begin
    state_d   = state_q;
    restart_d = 1'b0;
    unique case (state_q)
      ST_CLOSED: begin
        if (arrived || open_btn) state_d = ST_OPENING;
      end
      ST_OPENING: begin
        if (lim_open) begin
          state_d   = ST_OPEN_WAIT;
          restart_d = 1'b1;
        end else if (mot_expire) begin
          state_d = ST_FAULT;
        end
      end
      ST_OPEN_WAIT: begin
        // A stale timeExpired from before the restart is masked by guard_q.
        if (open_btn || obstruction) begin
          restart_d = 1'b1;
        end else if (close_btn) begin
          state_d = ST_CLOSING;
        end else if (timeExpired && (guard_q == '0)) begin
          state_d = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
`ifdef NUDGE_EN
        if (open_btn) begin
          state_d = ST_OPENING;
        end else if (obstruction) begin
          state_d = (reopen_q >= REOPEN_MAX) ? ST_NUDGE : ST_OPENING;
        end else
`else
        if (open_btn || obstruction) begin
          state_d = ST_OPENING;
        end else
`endif
        if (lim_closed) begin
          state_d = ST_CLOSED;
        end else if (mot_expire) begin
          state_d = ST_FAULT;
        end
      end
`ifdef NUDGE_EN
      ST_NUDGE: begin
        if (open_btn) begin
          state_d = ST_OPENING;
        end else if (lim_closed) begin
          state_d = ST_CLOSED;
        end else if (mot_expire) begin
          state_d = ST_FAULT;
        end
      end
`endif
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_CLOSED;
      end
    endcase
  end

  always_comb begin
    guard_d = guard_q;
    if (restart_d) begin
      guard_d = GUARD_INIT;
    end else if (guard_q != '0) begin
      guard_d = guard_q - GW'(1);
    end
  end

`ifdef NUDGE_EN
  always_comb begin
    reopen_d = reopen_q;
    if (state_q == ST_CLOSED) begin
      reopen_d = '0;
    end else if ((state_d == ST_OPENING) &&
                 ((state_q == ST_CLOSING) || (state_q == ST_NUDGE)) &&
                 (reopen_q != '1)) begin
      reopen_d = reopen_q + RW'(1);
    end
  end

  always_ff @(posedge C_100Mhz or posedge reset) begin
    if (reset) begin
      reopen_q <= '0;
    end else begin
      reopen_q <= reopen_d;
    end
  end
`endif

  always_ff @(posedge C_100Mhz or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLOSED;
      restart_q <= 1'b0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      restart_q <= restart_d;
      guard_q   <= guard_d;
    end
  end

  assign mot_en  = (state_q == ST_OPENING) || (state_q == ST_CLOSING)
                || (state_q == ST_NUDGE);
  assign mot_clr = (state_d != state_q);

  puerta_watchdog #(
    .TIMEOUT (MOTION_TIMEOUT)
  ) u_watchdog (
    .clk    (C_100Mhz),
    .rst    (reset),
    .clr    (mot_clr),
    .en     (mot_en),
    .expire (mot_expire)
  );

  // Outputs decode straight from registered state, so a reset drops them
  // immediately without waiting for a clock edge.
  always_comb begin
    startTimer  = (state_q == ST_OPEN_WAIT);
    restart     = restart_q;
    motor_open  = (state_q == ST_OPENING);
    motor_close = (state_q == ST_CLOSING) || (state_q == ST_NUDGE);
    door_busy   = (state_q != ST_CLOSED);
    fault       = (state_q == ST_FAULT);
  end

`ifdef NUDGE_EN
  assign nudge_buzzer = (state_q == ST_NUDGE);
`endif

endmodule

// File: tb/tb_controlador_puerta.sv
module tb_controlador_puerta;

  // vector layout: {nudge, startTimer, restart, motor_open, motor_close, door_busy, fault}
  localparam logic [6:0] V_CLOSED  = 7'b000_0000;
  localparam logic [6:0] V_OPENING = 7'b000_1010;
  localparam logic [6:0] V_OW_R    = 7'b011_0010;
  localparam logic [6:0] V_OW      = 7'b010_0010;
  localparam logic [6:0] V_CLOSING = 7'b000_0110;
  localparam logic [6:0] V_FAULT   = 7'b000_0011;
  localparam logic [6:0] V_NUDGE   = 7'b100_0110;

  logic C_100Mhz = 1'b0;
  logic reset = 1'b1;
  logic arrived = 1'b0, open_btn = 1'b0, close_btn = 1'b0, obstruction = 1'b0;
  logic lim_open = 1'b0, lim_closed = 1'b0, timeExpired = 1'b0;
  logic startTimer, restart, motor_open, motor_close, door_busy, fault;
  logic nudge_bit;

`ifdef NUDGE_EN
  logic nudge_buzzer;
  assign nudge_bit = nudge_buzzer;
`else
  assign nudge_bit = 1'b0;
`endif

  controlador_puerta #(
    .MOTION_TIMEOUT (32'd20),
    .GUARD          (2)
`ifdef NUDGE_EN
    , .MAX_REOPEN   (3)
`endif
  ) dut (
    .C_100Mhz    (C_100Mhz),
    .reset       (reset),
    .arrived     (arrived),
    .open_btn    (open_btn),
    .close_btn   (close_btn),
    .obstruction (obstruction),
    .lim_open    (lim_open),
    .lim_closed  (lim_closed),
    .timeExpired (timeExpired),
    .startTimer  (startTimer),
    .restart     (restart),
    .motor_open  (motor_open),
    .motor_close (motor_close),
    .door_busy   (door_busy),
    .fault       (fault)
`ifdef NUDGE_EN
    , .nudge_buzzer (nudge_buzzer)
`endif
  );

  always #5 C_100Mhz = ~C_100Mhz;

  int cyc = 0;
  always @(posedge C_100Mhz) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] vec;
    int         at;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_on  = 1'b0;
  logic [6:0] prev_vec = V_CLOSED;

  function automatic logic [6:0] out_vec();
    return {nudge_bit, startTimer, restart, motor_open, motor_close, door_busy, fault};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge C_100Mhz);
      #1;
    end
  endtask

  task automatic push_exp(input logic [6:0] v, input int at, input string name);
    exp_t e;
    e.vec  = v;
    e.at   = at;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // From OPENING: reach OPEN_WAIT via lim_open after two cycles.
  task automatic reach_open_wait(input string tag);
    tick(2);
    lim_open = 1'b1;
    push_exp(V_OW_R, cyc + 1, {tag, "_ow_restart"});
    push_exp(V_OW,   cyc + 2, {tag, "_ow"});
    tick(1);
    lim_open = 1'b0;
    tick(1);
  endtask

  task automatic close_now(input string tag);
    close_btn = 1'b1;
    push_exp(V_CLOSING, cyc + 1, {tag, "_closing"});
    tick(1);
    close_btn = 1'b0;
    tick(1);
  endtask

  task automatic finish_close(input string tag);
    tick(1);
    lim_closed = 1'b1;
    push_exp(V_CLOSED, cyc + 1, {tag, "_closed"});
    tick(1);
    lim_closed = 1'b0;
    tick(1);
  endtask

  // Scoreboard monitor: every change of the output vector is a DUT event.
  always @(negedge C_100Mhz) begin
    logic [6:0] cur;
    exp_t e;
    cur = out_vec();
    if (mon_on) begin
      n_tests++;
      if (motor_open && motor_close) begin
        n_fail++;
        $display("FAIL motor_excl: motor_open=%b motor_close=%b at cycle %0d, required not both 1",
                 motor_open, motor_close, cyc);
      end
      if (cur != prev_vec) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: vec=%b at cycle %0d, required no change from %b",
                   cur, cyc, prev_vec);
        end else begin
          e = sb_q.pop_front();
          if ((cur !== e.vec) || (cyc != e.at)) begin
            n_fail++;
            $display("FAIL %s: got vec=%b at cycle %0d, required vec=%b at cycle %0d",
                     e.name, cur, cyc, e.vec, e.at);
          end
        end
      end
    end
    prev_vec = cur;
  end

  initial begin
    // reset state
    #1;
    n_tests++;
    if (out_vec() !== V_CLOSED) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required %b", out_vec(), V_CLOSED);
    end
    tick(2);
    reset = 1'b0;
    tick(1);
    mon_on = 1'b1;

    // 1. basic cycle
    arrived = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t1_opening");
    tick(1);
    arrived = 1'b0;
    tick(3);
    lim_open = 1'b1;
    push_exp(V_OW_R, cyc + 1, "t1_ow_restart");
    push_exp(V_OW,   cyc + 2, "t1_ow");
    tick(1);
    lim_open = 1'b0;
    tick(14);
    timeExpired = 1'b1;
    push_exp(V_CLOSING, cyc + 1, "t1_closing");
    tick(1);
    timeExpired = 1'b0;
    tick(2);
    finish_close("t1");

    // 2. stale expire held across entry to OPEN_WAIT
    arrived = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t2_opening");
    tick(1);
    arrived = 1'b0;
    tick(2);
    lim_open = 1'b1;
    timeExpired = 1'b1;
    push_exp(V_OW_R,    cyc + 1, "t2_ow_restart");
    push_exp(V_OW,      cyc + 2, "t2_ow");
    push_exp(V_CLOSING, cyc + 4, "t2_guarded_close");
    tick(1);
    lim_open = 1'b0;
    tick(3);
    timeExpired = 1'b0;
    finish_close("t2");

    // 3. obstruction while closing overrides simultaneous lim_closed
    open_btn = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t3_opening");
    tick(1);
    open_btn = 1'b0;
    reach_open_wait("t3a");
    close_now("t3a");
    tick(1);
    obstruction = 1'b1;
    lim_closed = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t3_reopen");
    tick(1);
    obstruction = 1'b0;
    lim_closed = 1'b0;
    reach_open_wait("t3b");
    close_now("t3b");
    finish_close("t3");

    // 4. restart requests in OPEN_WAIT beat close_btn and timeExpired
    arrived = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t4_opening");
    tick(1);
    arrived = 1'b0;
    reach_open_wait("t4");
    tick(2);
    obstruction = 1'b1;
    close_btn = 1'b1;
    push_exp(V_OW_R, cyc + 1, "t4_obst_restart");
    push_exp(V_OW,   cyc + 2, "t4_obst_stay");
    tick(1);
    obstruction = 1'b0;
    close_btn = 1'b0;
    tick(2);
    open_btn = 1'b1;
    timeExpired = 1'b1;
    push_exp(V_OW_R,    cyc + 1, "t4_btn_restart");
    push_exp(V_OW,      cyc + 2, "t4_btn_stay");
    push_exp(V_CLOSING, cyc + 4, "t4_close_after_guard");
    tick(1);
    open_btn = 1'b0;
    tick(3);
    timeExpired = 1'b0;
    finish_close("t4");

    // 5. opening timeout, then asynchronous reset out of FAULT
    arrived = 1'b1;
    push_exp(V_OPENING, cyc + 1,  "t5_opening");
    push_exp(V_FAULT,   cyc + 21, "t5_fault");
    tick(1);
    arrived = 1'b0;
    tick(25);
    #1;
    reset = 1'b1;
    push_exp(V_CLOSED, cyc, "t5_async_reset");
    #1;
    n_tests++;
    if ((fault !== 1'b0) || (motor_open !== 1'b0) || (door_busy !== 1'b0)) begin
      n_fail++;
      $display("FAIL t5_reset_immediate: fault=%b motor_open=%b door_busy=%b, required 0 0 0",
               fault, motor_open, door_busy);
    end
    tick(1);
    reset = 1'b0;
    tick(1);

    // 5b. reset mid-stroke drops the motor without a clock edge
    arrived = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t5b_opening");
    tick(1);
    arrived = 1'b0;
    tick(2);
    #1;
    reset = 1'b1;
    push_exp(V_CLOSED, cyc, "t5b_async_reset");
    #1;
    n_tests++;
    if ((motor_open !== 1'b0) || (motor_close !== 1'b0)) begin
      n_fail++;
      $display("FAIL t5b_motor_drop: motor_open=%b motor_close=%b, required 0 0",
               motor_open, motor_close);
    end
    tick(1);
    reset = 1'b0;
    tick(1);

    // 6. repeated obstruction reopens; the fourth nudges when enabled
    arrived = 1'b1;
    push_exp(V_OPENING, cyc + 1, "t6_opening");
    tick(1);
    arrived = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reach_open_wait("t6_loop");
      close_now("t6_loop");
      obstruction = 1'b1;
      push_exp(V_OPENING, cyc + 1, "t6_reopen");
      tick(1);
      obstruction = 1'b0;
    end
    reach_open_wait("t6_last");
    close_now("t6_last");
    obstruction = 1'b1;
`ifdef NUDGE_EN
    push_exp(V_NUDGE, cyc + 1, "t6_nudge");
    tick(3);
    obstruction = 1'b0;
    finish_close("t6");
`else
    push_exp(V_OPENING, cyc + 1, "t6_fourth_reopen");
    tick(1);
    obstruction = 1'b0;
    reach_open_wait("t6_end");
    close_now("t6_end");
    finish_close("t6");
`endif

    tick(3);
    mon_on = 1'b0;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0 (next: %s)",
               sb_q.size(), sb_q[0].name);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before %0t", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/controlador_puerta.md
Name: controlador_puerta

Overview:
Door controller for the elevator car. It is the initiator side of the door-timer handshake: it drives startTimer/restart into the 10 s door timer and consumes its timeExpired. It also sequences the door motor from the limit switches and tells the main elevator FSM when the car may move.

Parameters:
MOTION_TIMEOUT, 300_000_000, max cycles allowed for a full open or close stroke (3 s at 100 MHz); exceeding it causes FAULT
MAX_REOPEN, 3, consecutive obstruction/button reopens before nudge (only used with NUDGE_EN)
GUARD, 2, cycles after a restart pulse during which timeExpired is ignored

Ports:
C_100Mhz  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-high reset
arrived  in  1  one-cycle pulse: car stopped level at a floor
open_btn  in  1  in-car door-open button, level
close_btn  in  1  in-car door-close button, level
obstruction  in  1  light-curtain blocked, level
lim_open  in  1  door fully-open limit switch
lim_closed  in  1  door fully-closed limit switch
timeExpired  in  1  from door timer; level, cleared by timer on restart
startTimer  out  1  timer enable, held high while waiting with door open
restart  out  1  one-cycle pulse that zeroes the timer
motor_open  out  1  drive door toward open
motor_close  out  1  drive door toward closed
door_busy  out  1  high whenever the car must not move
fault  out  1  sticky motion-timeout flag

Behaviour:
- Reset values: state CLOSED; all outputs 0 except door_busy=0; internal counters 0. Reset mid-stroke drops both motor outputs on the same edge (asynchronous).
- Invariant: motor_open and motor_close are never both 1.
- States and transitions:
  - CLOSED: motors off, door_busy=0. On arrived=1 or open_btn=1 → OPENING.
  - OPENING: motor_open=1, door_busy=1, motion counter increments.
    - lim_open=1 → OPEN_WAIT, with restart pulsed on the entry cycle.
    - Counter reaching MOTION_TIMEOUT → FAULT.
  - OPEN_WAIT: startTimer=1, door_busy=1, motors off, guard counter loads GUARD on every restart.
    - open_btn or obstruction → restart pulse, stay; these have priority over close_btn and timeExpired in the same cycle.
    - close_btn → CLOSING immediately.
    - timeExpired=1 with guard counter at 0 → CLOSING.
  - CLOSING: motor_close=1, door_busy=1, motion counter increments.
    - obstruction or open_btn → OPENING, reopen count +1; this has priority over lim_closed in the same cycle.
    - lim_closed=1 → CLOSED, reopen count cleared.
    - Timeout → FAULT.
  - FAULT: motors off, fault=1, door_busy=1; left only by reset.
- Latency: each input-driven transition is one cycle; outputs are registered and decoded from state.
- The motion counter clears on every state entry. It is 32 bits and saturates; no wrap.
- The timer is never relied on to clear itself. The GUARD window masks the stale high timeExpired left from the previous cycle.
- arrived while not in CLOSED is ignored.
- startTimer drops to 0 on the cycle CLOSING is entered.

Optional Feature:
NUDGE_EN:
- Defined: adds output nudge_buzzer and state NUDGE. From CLOSING, when reopen count reaches MAX_REOPEN, the next obstruction enters NUDGE instead of OPENING.
  - NUDGE: motor_close=1, nudge_buzzer=1, obstruction ignored, open_btn still reopens, lim_closed → CLOSED.
  - Timeout in NUDGE → FAULT.
- Undefined: no port, no state; obstruction always reopens.

Decomposition:
- Shared package elevador_pkg:
  - Door-state encoding typedef (CLOSED, OPENING, OPEN_WAIT, CLOSING, FAULT, NUDGE).
  - Default MOTION_TIMEOUT and GUARD constants.
- One natural sub-module: puerta_watchdog, the saturating motion counter with clear and timeout compare.

Test Plan:
All runs use MOTION_TIMEOUT=20 and GUARD=2.
1. Basic cycle: arrived pulse → motor_open next cycle. lim_open at cycle 5 → restart pulse, startTimer=1. timeExpired at cycle 20 → motor_close=1. lim_closed → door_busy=0.
2. Stale expire: timeExpired held high across entry to OPEN_WAIT → no close for 2 cycles after restart, then CLOSING.
3. Obstruction while closing: obstruction during CLOSING → OPENING next cycle. A simultaneous lim_closed=1 is overridden.
4. Restart in wait: open_btn in OPEN_WAIT at the same cycle as timeExpired → restart pulse, state stays OPEN_WAIT.
5. Timeout and reset: lim_open never asserted → fault=1 after 20 cycles in OPENING, motors 0. Asynchronous reset mid-FAULT → CLOSED, fault=0.
6. NUDGE_EN with MAX_REOPEN=3: 3 obstruction reopens, then a 4th obstruction → NUDGE, buzzer=1, motor_close held despite obstruction.
